// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions for the memory-stage access controller:
// write-back field positions, FSM encoding and the default abort timeout.
package mem_access_unit_pkg;

  // Bit positions inside the 2-bit write-back control field.
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  // Default number of WAIT cycles before an outstanding access is abandoned.
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the memory stage and memory.
//
// Handshake: the master raises req_o together with we_o, maddr_o and
// mwdata_o and holds all four stable until it sees ack_i. The slave answers
// with a single-cycle ack_i pulse; for reads mrdata_i is valid only in that
// cycle. The master may withdraw req_o without an ack (timeout or reset),
// so the slave must tolerate an abandoned request. At most one request is
// outstanding at a time.
interface mem_access_unit_if;

  logic        req_o;
  logic        we_o;
  logic [31:0] maddr_o;
  logic [31:0] mwdata_o;
  logic        ack_i;
  logic [31:0] mrdata_i;

  modport master (
    output req_o,
    output we_o,
    output maddr_o,
    output mwdata_o,
    input  ack_i,
    input  mrdata_i
  );

  modport slave (
    input  req_o,
    input  we_o,
    input  maddr_o,
    input  mwdata_o,
    output ack_i,
    output mrdata_i
  );

endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues data-memory requests for aligned
// loads/stores, stalls the pipeline while one is outstanding, aborts on
// timeout, and registers the stage result into the MEM/WB outputs.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [1:0]         WB_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic [31:0]        ALU_i,
  input  logic [31:0]        wdata_i,
  input  logic [4:0]         rd_i,
  mem_access_unit_if.master  mem,
  output logic               stall_o,
  output logic [1:0]         WB_o,
  output logic [31:0]        rdata_o,
  output logic [31:0]        ALU_o,
  output logic [4:0]         rd_o,
  output logic               err_o,
  output state_t             state_o
);

  // Last count value in WAIT before the access is abandoned.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;

  logic is_mem;
  logic aligned;
  logic accept;
  logic misalign;
  logic done;
  logic tmo;

  assign is_mem  = MemRead_i | MemWrite_i;
  assign aligned = (ALU_i[1:0] == 2'b00);
  assign state_o = state;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, stall and datapath control decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    misalign  = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          if (aligned) begin
            accept    = 1'b1;
            stall_o   = 1'b1;
            state_nxt = WAIT;
          end else begin
            misalign  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (mem.ack_i) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == TIMEOUT_CNT) begin
          // Release the pipeline in the abort cycle itself.
          tmo       = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_o   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Never hold the pipeline while it is being reset.
    if (!rst_n_i) stall_o = 1'b0;
  end

  // Request bus, timeout counter, error flag and MEM/WB output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem.req_o    <= 1'b0;
      mem.we_o     <= 1'b0;
      mem.maddr_o  <= '0;
      mem.mwdata_o <= '0;
      WB_o         <= '0;
      rdata_o      <= '0;
      ALU_o        <= '0;
      rd_o         <= '0;
      err_o        <= 1'b0;
      cnt          <= '0;
    end else if (accept) begin
      // A set MemWrite_i wins when both controls are high.
      mem.maddr_o  <= ALU_i;
      mem.mwdata_o <= wdata_i;
      mem.we_o     <= MemWrite_i;
      mem.req_o    <= 1'b1;
      cnt          <= '0;
      WB_o         <= '0;
    end else if (misalign) begin
      err_o        <= 1'b1;
      WB_o         <= '0;
      rd_o         <= rd_i;
    end else if (state == IDLE) begin
      WB_o         <= WB_i;
      ALU_o        <= ALU_i;
      rd_o         <= rd_i;
    end else if (done) begin
      mem.req_o    <= 1'b0;
      WB_o         <= WB_i;
      ALU_o        <= ALU_i;
      rd_o         <= rd_i;
      if (!mem.we_o) rdata_o <= mem.mrdata_i;
    end else if (tmo) begin
      mem.req_o    <= 1'b0;
      err_o        <= 1'b1;
      WB_o         <= '0;
    end else begin
      cnt          <= cnt + 8'd1;
      WB_o         <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, load/store with
// variable ack latency, misaligned access, timeout, back-to-back accesses
// and asynchronous reset in the middle of an access.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk_i;
  logic        rst_n_i;
  logic [1:0]  WB_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] ALU_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic [1:0]  WB_o;
  logic [31:0] rdata_o;
  logic [31:0] ALU_o;
  logic [4:0]  rd_o;
  logic        err_o;
  state_t      state_o;

  int chk_cnt;
  int pass_cnt;

  mem_access_unit_if mem_if ();

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .WB_i       (WB_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .ALU_i      (ALU_i),
    .wdata_i    (wdata_i),
    .rd_i       (rd_i),
    .mem        (mem_if.master),
    .stall_o    (stall_o),
    .WB_o       (WB_o),
    .rdata_o    (rdata_o),
    .ALU_o      (ALU_o),
    .rd_o       (rd_o),
    .err_o      (err_o),
    .state_o    (state_o)
  );

  // Clock and reset.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_nop(input logic [1:0] wb, input logic [31:0] alu, input logic [4:0] rd);
    WB_i = wb; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    ALU_i = alu; wdata_i = 32'h0; rd_i = rd;
  endtask

  task automatic drive_mem(input logic rd_en, input logic wr_en, input logic [1:0] wb,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    WB_i = wb; MemRead_i = rd_en; MemWrite_i = wr_en;
    ALU_i = addr; wdata_i = wd; rd_i = rd;
  endtask

  task automatic apply_reset();
    drive_nop(2'b00, 32'h0, 5'd0);
    mem_if.ack_i = 1'b0; mem_if.mrdata_i = 32'h0;
    rst_n_i = 1'b0;
    step(); step();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    chk_cnt++; if (mem_if.req_o !== 1'b0) $display("FAIL reset_req actual=%0b expected=0", mem_if.req_o); else pass_cnt++;
    chk_cnt++; if (mem_if.we_o !== 1'b0) $display("FAIL reset_we actual=%0b expected=0", mem_if.we_o); else pass_cnt++;
    chk_cnt++; if (mem_if.maddr_o !== 32'h0) $display("FAIL reset_maddr actual=%h expected=0", mem_if.maddr_o); else pass_cnt++;
    chk_cnt++; if (WB_o !== 2'b00) $display("FAIL reset_wb actual=%b expected=00", WB_o); else pass_cnt++;
    chk_cnt++; if (rdata_o !== 32'h0) $display("FAIL reset_rdata actual=%h expected=0", rdata_o); else pass_cnt++;
    chk_cnt++; if (ALU_o !== 32'h0) $display("FAIL reset_alu actual=%h expected=0", ALU_o); else pass_cnt++;
    chk_cnt++; if (rd_o !== 5'd0) $display("FAIL reset_rd actual=%0d expected=0", rd_o); else pass_cnt++;
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err actual=%0b expected=0", err_o); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL reset_stall actual=%0b expected=0", stall_o); else pass_cnt++;
    chk_cnt++; if (state_o !== IDLE) $display("FAIL reset_state actual=%0d expected=0", state_o); else pass_cnt++;
  endtask

  task automatic test_alu_op();
    drive_nop(2'b10, 32'h1234, 5'd5);
    #1;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL alu_stall actual=%0b expected=0", stall_o); else pass_cnt++;
    step();
    chk_cnt++; if (WB_o !== 2'b10) $display("FAIL alu_wb actual=%b expected=10", WB_o); else pass_cnt++;
    chk_cnt++; if (ALU_o !== 32'h1234) $display("FAIL alu_alu actual=%h expected=1234", ALU_o); else pass_cnt++;
    chk_cnt++; if (rd_o !== 5'd5) $display("FAIL alu_rd actual=%0d expected=5", rd_o); else pass_cnt++;
    chk_cnt++; if (mem_if.req_o !== 1'b0) $display("FAIL alu_req actual=%0b expected=0", mem_if.req_o); else pass_cnt++;
  endtask

  // Load at 0x100, ack in the fourth WAIT cycle.
  task automatic test_load();
    int stall_n;
    int req_n;
    stall_n = 0; req_n = 0;
    drive_mem(1'b1, 1'b0, 2'b11, 32'h100, 32'h0, 5'd7);
    #1;
    if (stall_o === 1'b1) stall_n++;
    if (mem_if.req_o === 1'b1) req_n++;
    step();
    for (int i = 0; i < 3; i++) begin
      chk_cnt++; if (mem_if.maddr_o !== 32'h100) $display("FAIL load_maddr actual=%h expected=100", mem_if.maddr_o); else pass_cnt++;
      chk_cnt++; if (mem_if.we_o !== 1'b0) $display("FAIL load_we actual=%0b expected=0", mem_if.we_o); else pass_cnt++;
      chk_cnt++; if (WB_o !== 2'b00) $display("FAIL load_bubble actual=%b expected=00", WB_o); else pass_cnt++;
      if (stall_o === 1'b1) stall_n++;
      if (mem_if.req_o === 1'b1) req_n++;
      step();
    end
    mem_if.ack_i = 1'b1; mem_if.mrdata_i = 32'hDEADBEEF;
    #1;
    if (stall_o === 1'b1) stall_n++;
    if (mem_if.req_o === 1'b1) req_n++;
    step();
    mem_if.ack_i = 1'b0; mem_if.mrdata_i = 32'h0;
    drive_nop(2'b00, 32'h0, 5'd0);
    chk_cnt++; if (stall_n !== 4) $display("FAIL load_stall_cycles actual=%0d expected=4", stall_n); else pass_cnt++;
    chk_cnt++; if (req_n !== 4) $display("FAIL load_req_cycles actual=%0d expected=4", req_n); else pass_cnt++;
    chk_cnt++; if (rdata_o !== 32'hDEADBEEF) $display("FAIL load_rdata actual=%h expected=deadbeef", rdata_o); else pass_cnt++;
    chk_cnt++; if (WB_o !== 2'b11) $display("FAIL load_wb actual=%b expected=11", WB_o); else pass_cnt++;
    chk_cnt++; if (rd_o !== 5'd7) $display("FAIL load_rd actual=%0d expected=7", rd_o); else pass_cnt++;
    chk_cnt++; if (mem_if.req_o !== 1'b0) $display("FAIL load_req_drop actual=%0b expected=0", mem_if.req_o); else pass_cnt++;
    chk_cnt++; if (state_o !== IDLE) $display("FAIL load_state actual=%0d expected=0", state_o); else pass_cnt++;
  endtask

  // Store with ack in the first WAIT cycle; rd_en selects the both-high case.
  task automatic test_store(input logic rd_en, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp_rdata);
    int stall_n;
    stall_n = 0;
    drive_mem(rd_en, 1'b1, 2'b00, addr, wd, 5'd0);
    #1;
    if (stall_o === 1'b1) stall_n++;
    step();
    chk_cnt++; if (mem_if.we_o !== 1'b1) $display("FAIL store_we actual=%0b expected=1", mem_if.we_o); else pass_cnt++;
    chk_cnt++; if (mem_if.mwdata_o !== wd) $display("FAIL store_wdata actual=%h expected=%h", mem_if.mwdata_o, wd); else pass_cnt++;
    chk_cnt++; if (mem_if.maddr_o !== addr) $display("FAIL store_maddr actual=%h expected=%h", mem_if.maddr_o, addr); else pass_cnt++;
    chk_cnt++; if (mem_if.req_o !== 1'b1) $display("FAIL store_req actual=%0b expected=1", mem_if.req_o); else pass_cnt++;
    mem_if.ack_i = 1'b1; mem_if.mrdata_i = 32'h77777777;
    #1;
    if (stall_o === 1'b1) stall_n++;
    step();
    mem_if.ack_i = 1'b0; mem_if.mrdata_i = 32'h0;
    drive_nop(2'b00, 32'h0, 5'd0);
    chk_cnt++; if (stall_n !== 1) $display("FAIL store_stall_cycles actual=%0d expected=1", stall_n); else pass_cnt++;
    chk_cnt++; if (rdata_o !== exp_rdata) $display("FAIL store_rdata_kept actual=%h expected=%h", rdata_o, exp_rdata); else pass_cnt++;
    chk_cnt++; if (mem_if.req_o !== 1'b0) $display("FAIL store_req_drop actual=%0b expected=0", mem_if.req_o); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    drive_mem(1'b1, 1'b0, 2'b11, 32'h102, 32'h0, 5'd9);
    #1;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL mis_stall actual=%0b expected=0", stall_o); else pass_cnt++;
    step();
    drive_nop(2'b00, 32'h0, 5'd0);
    chk_cnt++; if (mem_if.req_o !== 1'b0) $display("FAIL mis_req actual=%0b expected=0", mem_if.req_o); else pass_cnt++;
    chk_cnt++; if (err_o !== 1'b1) $display("FAIL mis_err actual=%0b expected=1", err_o); else pass_cnt++;
    chk_cnt++; if (WB_o !== 2'b00) $display("FAIL mis_wb actual=%b expected=00", WB_o); else pass_cnt++;
    chk_cnt++; if (rd_o !== 5'd9) $display("FAIL mis_rd actual=%0d expected=9", rd_o); else pass_cnt++;
    chk_cnt++; if (state_o !== IDLE) $display("FAIL mis_state actual=%0d expected=0", state_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive_mem(1'b1, 1'b0, 2'b11, 32'h600, 32'h0, 5'd3);
    step();
    mem_if.ack_i = 1'b1; mem_if.mrdata_i = 32'h0000000A;
    step();
    mem_if.ack_i = 1'b0;
    drive_mem(1'b1, 1'b0, 2'b11, 32'h604, 32'h0, 5'd4);
    chk_cnt++; if (rdata_o !== 32'h0000000A) $display("FAIL b2b_rdata_a actual=%h expected=a", rdata_o); else pass_cnt++;
    chk_cnt++; if (mem_if.req_o !== 1'b0) $display("FAIL b2b_gap_req actual=%0b expected=0", mem_if.req_o); else pass_cnt++;
    #1;
    chk_cnt++; if (stall_o !== 1'b1) $display("FAIL b2b_stall actual=%0b expected=1", stall_o); else pass_cnt++;
    step();
    chk_cnt++; if (mem_if.maddr_o !== 32'h604) $display("FAIL b2b_maddr actual=%h expected=604", mem_if.maddr_o); else pass_cnt++;
    mem_if.ack_i = 1'b1; mem_if.mrdata_i = 32'h0000000B;
    step();
    mem_if.ack_i = 1'b0;
    drive_nop(2'b00, 32'h0, 5'd0);
    chk_cnt++; if (rdata_o !== 32'h0000000B) $display("FAIL b2b_rdata_b actual=%h expected=b", rdata_o); else pass_cnt++;
    chk_cnt++; if (ALU_o !== 32'h604) $display("FAIL b2b_alu actual=%h expected=604", ALU_o); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int req_n;
    int stall_n;
    logic stall_last;
    apply_reset();
    req_n = 0; stall_n = 0; stall_last = 1'bx;
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL tmo_err_clear actual=%0b expected=0", err_o); else pass_cnt++;
    drive_mem(1'b1, 1'b0, 2'b11, 32'h400, 32'h0, 5'd6);
    #1;
    if (stall_o === 1'b1) stall_n++;
    step();
    for (int i = 0; i < 40; i++) begin
      if (mem_if.req_o !== 1'b1) break;
      req_n++;
      if (stall_o === 1'b1) stall_n++;
      stall_last = stall_o;
      step();
    end
    drive_nop(2'b10, 32'h99, 5'd2);
    chk_cnt++; if (req_n !== 15) $display("FAIL tmo_req_cycles actual=%0d expected=15", req_n); else pass_cnt++;
    chk_cnt++; if (stall_n !== 15) $display("FAIL tmo_stall_cycles actual=%0d expected=15", stall_n); else pass_cnt++;
    chk_cnt++; if (stall_last !== 1'b0) $display("FAIL tmo_stall_release actual=%0b expected=0", stall_last); else pass_cnt++;
    chk_cnt++; if (err_o !== 1'b1) $display("FAIL tmo_err actual=%0b expected=1", err_o); else pass_cnt++;
    chk_cnt++; if (WB_o !== 2'b00) $display("FAIL tmo_wb actual=%b expected=00", WB_o); else pass_cnt++;
    mem_if.ack_i = 1'b1; mem_if.mrdata_i = 32'h55555555;
    step();
    mem_if.ack_i = 1'b0; mem_if.mrdata_i = 32'h0;
    chk_cnt++; if (rdata_o !== 32'h0) $display("FAIL tmo_late_ack_rdata actual=%h expected=0", rdata_o); else pass_cnt++;
    chk_cnt++; if (state_o !== IDLE) $display("FAIL tmo_late_ack_state actual=%0d expected=0", state_o); else pass_cnt++;
    chk_cnt++; if (WB_o !== 2'b10) $display("FAIL tmo_next_wb actual=%b expected=10", WB_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    drive_mem(1'b1, 1'b0, 2'b11, 32'h500, 32'h0, 5'd8);
    step();
    step();
    chk_cnt++; if (mem_if.req_o !== 1'b1) $display("FAIL rstw_req_before actual=%0b expected=1", mem_if.req_o); else pass_cnt++;
    rst_n_i = 1'b0;
    #1;
    chk_cnt++; if (mem_if.req_o !== 1'b0) $display("FAIL rstw_req actual=%0b expected=0", mem_if.req_o); else pass_cnt++;
    chk_cnt++; if (stall_o !== 1'b0) $display("FAIL rstw_stall actual=%0b expected=0", stall_o); else pass_cnt++;
    chk_cnt++; if (mem_if.maddr_o !== 32'h0) $display("FAIL rstw_maddr actual=%h expected=0", mem_if.maddr_o); else pass_cnt++;
    chk_cnt++; if (err_o !== 1'b0) $display("FAIL rstw_err actual=%0b expected=0", err_o); else pass_cnt++;
    chk_cnt++; if (state_o !== IDLE) $display("FAIL rstw_state actual=%0d expected=0", state_o); else pass_cnt++;
    drive_nop(2'b00, 32'h0, 5'd0);
    step();
    rst_n_i = 1'b1;
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    mem_if.ack_i = 1'b0;
    mem_if.mrdata_i = 32'h0;
    rst_n_i = 1'b1;
    drive_nop(2'b00, 32'h0, 5'd0);
    test_reset();
    test_alu_op();
    test_load();
    test_store(1'b0, 32'h200, 32'h0000CAFE, 32'hDEADBEEF);
    test_store(1'b1, 32'h300, 32'h00001111, 32'hDEADBEEF);
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
